// File: rtl/inst_issue_unit.sv
// rtl/inst_issue_unit.sv - instruction fetch/issue front end with RAW bubble insertion and drain
module inst_issue_unit #(
    parameter int ISIZE     = 32,
    parameter int AW        = 6,
    parameter int HAZ_DEPTH = 2,
    parameter int DRAIN_CYC = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_en,
    input  logic [AW-1:0]    load_addr,
    input  logic [ISIZE-1:0] load_data,
    input  logic             start,
    input  logic [AW:0]      prog_len,
    output logic [ISIZE-1:0] inst,
    output logic             inst_valid,
    output logic [AW:0]      pc,
    output logic             busy,
    output logic             done,
    output logic [15:0]      stall_cnt
);

    localparam int DW = $clog2(DRAIN_CYC + 1) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t state, state_n;

    logic [ISIZE-1:0] imem [2**AW];
    logic [4:0]       hist [HAZ_DEPTH];
    logic [AW:0]      len, len_n;
    logic [DW-1:0]    drain_cnt, drain_n;

    logic [ISIZE-1:0] inst_n;
    logic             valid_n;
    logic [AW:0]      pc_n, pc_inc;
    logic [15:0]      stall_n;
    logic             done_n;
    logic [4:0]       hist_in;
    logic             clr_hist;

    logic [ISIZE-1:0] cand;
    logic             is_r;
    logic [4:0]       src_rs, src_rt, dest;
    logic             hazard;

    // imem has no reset so a program survives rst and can be re-run
    always_ff @(posedge clk) begin
        if (load_en && state == S_IDLE)
            imem[load_addr] <= load_data;
    end

    assign cand   = imem[pc[AW-1:0]];
    assign is_r   = (cand[31:26] == 6'd0);
    assign src_rs = cand[25:21];
    assign src_rt = cand[20:16];
    assign dest   = is_r ? cand[15:11] : cand[20:16];
    assign pc_inc = pc + (AW+1)'(1);
    assign busy   = (state == S_RUN) || (state == S_DRAIN);

    // I-type rt is a destination, so only R-type compares rt against history
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < HAZ_DEPTH; i++) begin
            if (hist[i] != 5'd0 &&
                (hist[i] == src_rs || (is_r && hist[i] == src_rt)))
                hazard = 1'b1;
        end
    end

    always_comb begin
        state_n  = state;
        inst_n   = '0;
        valid_n  = 1'b0;
        pc_n     = pc;
        len_n    = len;
        stall_n  = stall_cnt;
        done_n   = 1'b0;
        drain_n  = drain_cnt;
        hist_in  = 5'd0;
        clr_hist = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    len_n    = prog_len;
                    pc_n     = '0;
                    stall_n  = '0;
                    drain_n  = '0;
                    clr_hist = 1'b1;
                    state_n  = (prog_len == '0) ? S_DRAIN : S_RUN;
                end
            end
            S_RUN: begin
                if (hazard) begin
                    if (stall_cnt != 16'hFFFF)
                        stall_n = stall_cnt + 16'd1;
                end else begin
                    inst_n  = cand;
                    valid_n = 1'b1;
                    pc_n    = pc_inc;
                    hist_in = dest;
                    if (pc_inc == len) begin
                        state_n = S_DRAIN;
                        drain_n = '0;
                    end
                end
            end
            S_DRAIN: begin
                // DRAIN_CYC NOP edges, then the edge that raises done
                if (drain_cnt == DW'(DRAIN_CYC)) begin
                    done_n  = 1'b1;
                    state_n = S_IDLE;
                end else begin
                    drain_n = drain_cnt + DW'(1);
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            inst       <= '0;
            inst_valid <= 1'b0;
            pc         <= '0;
            len        <= '0;
            stall_cnt  <= '0;
            done       <= 1'b0;
            drain_cnt  <= '0;
        end else begin
            state      <= state_n;
            inst       <= inst_n;
            inst_valid <= valid_n;
            pc         <= pc_n;
            len        <= len_n;
            stall_cnt  <= stall_n;
            done       <= done_n;
            drain_cnt  <= drain_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < HAZ_DEPTH; i++)
                hist[i] <= 5'd0;
        end else if (clr_hist) begin
            for (int i = 0; i < HAZ_DEPTH; i++)
                hist[i] <= 5'd0;
        end else begin
            for (int i = HAZ_DEPTH - 1; i > 0; i--)
                hist[i] <= hist[i-1];
            hist[0] <= hist_in;
        end
    end

endmodule

// File: tb/tb_inst_issue_unit.sv
// tb/tb_inst_issue_unit.sv - directed self-checking bench for inst_issue_unit
module tb_inst_issue_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_en;
    logic [5:0]  load_addr;
    logic [31:0] load_data;
    logic        start;
    logic [6:0]  prog_len;
    logic [31:0] inst;
    logic        inst_valid;
    logic [6:0]  pc;
    logic        busy;
    logic        done;
    logic [15:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    inst_issue_unit #(.ISIZE(32), .AW(6), .HAZ_DEPTH(2), .DRAIN_CYC(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .start     (start),
        .prog_len  (prog_len),
        .inst      (inst),
        .inst_valid(inst_valid),
        .pc        (pc),
        .busy      (busy),
        .done      (done),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [5:0] a, input logic [31:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        tick();
        load_en = 1'b0;
    endtask

    task automatic kick(input logic [6:0] n);
        start    = 1'b1;
        prog_len = n;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 12 && busy; i++) tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s drain timeout busy=%b want 0", name, busy);
        end
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({inst, inst_valid, pc, busy, done, stall_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_values inst=%h v=%b pc=%0d busy=%b done=%b stall=%0d want all 0",
                     inst, inst_valid, pc, busy, done, stall_cnt);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_independent();
        logic [31:0] exp_i [7] = '{32'h00221820, 32'h00A63020, 0, 0, 0, 0, 0};
        logic        exp_v [7] = '{1, 1, 0, 0, 0, 0, 0};
        logic        exp_d [7] = '{0, 0, 0, 0, 1, 0, 0};
        logic        exp_b [7] = '{1, 1, 1, 1, 0, 0, 0};
        load(6'd0, 32'h00221820);
        load(6'd1, 32'h00A63020);
        kick(7'd2);
        for (int c = 0; c < 6; c++) begin
            tick();
            checks++;
            if (inst !== exp_i[c] || inst_valid !== exp_v[c] || done !== exp_d[c] || busy !== exp_b[c]) begin
                errors++;
                $display("FAIL indep cyc%0d inst=%h v=%b done=%b busy=%b want %h %b %b %b",
                         c, inst, inst_valid, done, busy, exp_i[c], exp_v[c], exp_d[c], exp_b[c]);
            end
        end
        checks++;
        if (stall_cnt !== 16'd0 || pc !== 7'd2) begin
            errors++;
            $display("FAIL indep_stall stall=%0d pc=%0d want 0 2", stall_cnt, pc);
        end
    endtask

    task automatic test_raw();
        logic [31:0] exp_i [4] = '{32'h00221820, 0, 0, 32'h00612020};
        logic        exp_v [4] = '{1, 0, 0, 1};
        logic [6:0]  exp_pc [4] = '{1, 1, 1, 2};
        load(6'd0, 32'h00221820);
        load(6'd1, 32'h00612020);
        kick(7'd2);
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (inst !== exp_i[c] || inst_valid !== exp_v[c] || pc !== exp_pc[c]) begin
                errors++;
                $display("FAIL raw cyc%0d inst=%h v=%b pc=%0d want %h %b %0d",
                         c, inst, inst_valid, pc, exp_i[c], exp_v[c], exp_pc[c]);
            end
        end
        checks++;
        if (stall_cnt !== 16'd2) begin
            errors++;
            $display("FAIL raw_stall stall=%0d want 2", stall_cnt);
        end
        wait_idle("raw");
    endtask

    task automatic test_pair_no_stall(input string name, input logic [31:0] a, input logic [31:0] b);
        load(6'd0, a);
        load(6'd1, b);
        kick(7'd2);
        tick();
        checks++;
        if (inst !== a || inst_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s first inst=%h v=%b want %h 1", name, inst, inst_valid, a);
        end
        tick();
        checks++;
        if (inst !== b || inst_valid !== 1'b1 || stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL %s second inst=%h v=%b stall=%0d want %h 1 0", name, inst, inst_valid, stall_cnt, b);
        end
        wait_idle(name);
    endtask

    task automatic test_empty();
        logic exp_d [4] = '{0, 0, 1, 0};
        kick(7'd0);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL empty_busy busy=%b want 1", busy);
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (done !== exp_d[c] || inst_valid !== 1'b0) begin
                errors++;
                $display("FAIL empty cyc%0d done=%b v=%b want %b 0", c, done, inst_valid, exp_d[c]);
            end
        end
    endtask

    task automatic test_ignore_busy();
        logic [31:0] exp_i [4] = '{0, 0, 32'h00612020, 0};
        load(6'd0, 32'h00221820);
        load(6'd1, 32'h00612020);
        kick(7'd2);
        tick();
        start     = 1'b1;
        prog_len  = 7'd0;
        load_en   = 1'b1;
        load_addr = 6'd0;
        load_data = 32'hFFFFFFFF;
        tick();
        start   = 1'b0;
        load_en = 1'b0;
        checks++;
        if (pc !== 7'd1 || busy !== 1'b1 || stall_cnt !== 16'd1) begin
            errors++;
            $display("FAIL busy_restart pc=%0d busy=%b stall=%0d want 1 1 1", pc, busy, stall_cnt);
        end
        for (int c = 1; c < 3; c++) begin
            tick();
            checks++;
            if (inst !== exp_i[c]) begin
                errors++;
                $display("FAIL busy_seq cyc%0d inst=%h want %h", c, inst, exp_i[c]);
            end
        end
        wait_idle("busy");
        kick(7'd2);
        tick();
        checks++;
        if (inst !== 32'h00221820 || inst_valid !== 1'b1) begin
            errors++;
            $display("FAIL busy_imem inst=%h v=%b want 00221820 1", inst, inst_valid);
        end
        wait_idle("busy_rerun");
    endtask

    task automatic test_reset_mid_run();
        kick(7'd2);
        tick();
        tick();
        rst = 1'b1;
        #2;
        checks++;
        if (inst !== 32'h0 || inst_valid !== 1'b0 || busy !== 1'b0 || pc !== 7'd0 || stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL async_reset inst=%h v=%b busy=%b pc=%0d stall=%0d want 0 0 0 0 0",
                     inst, inst_valid, busy, pc, stall_cnt);
        end
        tick();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL reset_no_done cyc%0d done=%b want 0", c, done);
            end
        end
        kick(7'd2);
        tick();
        checks++;
        if (inst !== 32'h00221820 || inst_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_imem inst=%h v=%b want 00221820 1", inst, inst_valid);
        end
        wait_idle("reset_rerun");
    endtask

    initial begin
        rst       = 1'b1;
        load_en   = 1'b0;
        load_addr = '0;
        load_data = '0;
        start     = 1'b0;
        prog_len  = '0;
        test_reset();
        test_independent();
        test_raw();
        test_pair_no_stall("itype_rt", 32'h00221820, 32'h20230004);
        test_pair_no_stall("zero_dest", 32'h00220020, 32'h00002820);
        test_empty();
        test_ignore_busy();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_issue_unit.md
Name: inst_issue_unit

Overview:
- Instruction-side front end for the four-stage pipelined datapath: holds a loadable instruction memory, fetches sequentially and drives the datapath's inst input one instruction per cycle.
- The datapath has no forwarding, so this block detects RAW hazards against in-flight destinations and inserts NOP bubbles (32'h0).
- After the last instruction it drains the pipeline, then flags done.

Parameters:
- ISIZE, 32, instruction width
- AW, 6, instruction memory address width (depth 2**AW)
- HAZ_DEPTH, 2, number of most recently issued destinations checked for hazards
- DRAIN_CYC, 2, NOP cycles issued after the last instruction before done

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- load_en  in  1  write load_data to imem[load_addr]; accepted only in IDLE
- load_addr  in  AW  imem write address
- load_data  in  ISIZE  imem write data
- start  in  1  begin issuing from address 0; accepted only in IDLE
- prog_len  in  AW+1  number of instructions, sampled when start is accepted
- inst  out  ISIZE  registered instruction to the datapath; 32'h0 = NOP
- inst_valid  out  1  inst holds a real (non-bubble) instruction
- pc  out  AW+1  address of next instruction to issue
- busy  out  1  state is RUN or DRAIN
- done  out  1  single-cycle pulse when drain completes
- stall_cnt  out  16  bubbles inserted for hazards since last start; saturates at 16'hFFFF

Behaviour:
Decode (fixed):
- Opcode inst[31:26]==0: R-type; sources rs=[25:21], rt=[20:16]; destination rd=[15:11].
- Any other opcode: I-type; source rs; destination rt.
- Destination 0 is never a hazard.

Reset (async, rst=1):
- State=IDLE; inst=0, inst_valid=0, pc=0, busy=0, done=0, stall_cnt=0.
- Destination history cleared to 0.
- imem contents are not cleared.

IDLE:
- load_en writes imem synchronously.
- start=1: latch prog_len, pc=0, stall_cnt=0, history=0.
  - If prog_len==0, go to DRAIN.
  - Otherwise go to RUN.
- If load_en and start are asserted together, the write completes and start is also accepted.

RUN (each cycle), candidate = imem[pc]:
- Hazard when any candidate source equals a nonzero entry in the HAZ_DEPTH-deep history. R-type checks rs and rt; I-type checks rs only.
- On hazard:
  - next inst=0, inst_valid=0; pc holds.
  - stall_cnt+1.
  - History shifts in 0.
- No hazard:
  - next inst=candidate, inst_valid=1; pc+1.
  - History shifts in the candidate destination.
- When pc+1==prog_len on an issue, go to DRAIN.

DRAIN:
- Issue NOPs (inst=0, inst_valid=0) for DRAIN_CYC cycles; history shifts in 0.
- Then pulse done for one cycle and return to IDLE.

General rules:
- Latency: start accepted at edge k; first instruction appears on inst after edge k+1.
- start and load_en are ignored while busy.
- Asserting rst mid-RUN or mid-DRAIN aborts immediately to reset values; no done pulse.
- pc never exceeds prog_len; imem address wraps only if prog_len > 2**AW, which is illegal.

Test Plan:
- Reset values: rst asserted mid-RUN -> inst=0, busy=0, pc=0, stall_cnt=0 on the same cycle, without waiting for a clock edge; imem still readable on the next run.
- Independent stream:
  - Load imem[0]=32'h00221820 (r3=r1+r2), imem[1]=32'h00A63020 (r6=r5+r6), prog_len=2.
  - Expect both issued back-to-back on consecutive cycles, stall_cnt=0.
  - Then 2 NOP cycles, then done pulses once.
- R-type RAW:
  - imem[0]=32'h00221820 (writes r3), imem[1]=32'h00612020 (reads r3).
  - Expect issue, NOP, NOP, issue; stall_cnt=2; inst_valid pattern 1,0,0,1.
- rt-only hazard on I-type:
  - imem[0] writes r3; imem[1] is I-type (opcode 6'h08) with rs=1, rt=3.
  - Expect no stall, because an I-type rt is a destination, not a source.
- Zero destination and empty program:
  - Producer with rd=0 followed by a consumer reading r0 -> no stall.
  - start with prog_len=0 -> no inst_valid, done 3 cycles after start.
- Ignored inputs while busy:
  - start and load_en asserted during RUN -> no restart and imem unchanged.
  - Subsequent run reissues the original program.
